// File: rtl/tx_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_controller : UART transmitter, start + 8 data bits LSB first + optional
//                 parity + 1/2 stop bits, valid/ready byte intake.  Rev 1.0
// ----------------------------------------------------------------------------
module tx_controller #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_EN    = (PARITY_EN != 0);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             data_q, data_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (i_valid) begin
          shift_d  = i_byte;
          parity_d = (^i_byte) ^ PAR_ODD;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = TX_START;
        end
      end

      TX_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TX_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          // The byte shifts right so the current data bit is always shift_q[0].
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TX_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so the registered output
  // changes on the same edge as the state.
  always_comb begin
    data_d = 1'b1;
    case (state_d)
      TX_START:  data_d = 1'b0;
      TX_DATA:   data_d = shift_d[0];
      TX_PARITY: data_d = parity_d;
      default:   data_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      data_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign o_ready = (state_q == TX_IDLE);
  assign o_busy  = (state_q != TX_IDLE);
  assign o_data  = data_q;
  assign o_done  = done_q;

endmodule
`default_nettype wire
